// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell driven once per bit-step by serial_adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell reused over WIDTH clocks,
// LSB first, with the carry held in a flip-flop between bit-steps.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH:0]   res_ext;
    logic [WIDTH-1:0] res_d;

    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_s),
        .cout (fa_c)
    );

    // Widened concat keeps the shift-in legal for WIDTH==1.
    assign res_ext = {fa_s, res_sh_q};
    assign res_d   = res_ext[WIDTH:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    res_sh_q <= res_d;
                    carry_q  <= fa_c;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        sum_q   <= res_d;
                        cout_q  <= fa_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8 and WIDTH=1).
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int tests;
    int fails;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller sits at a negedge; lat = edges after the accept edge until done seen.
    task automatic run_op(
        input  logic [7:0] ta,
        input  logic [7:0] tb,
        input  logic       tc,
        input  int         glitch_at,
        input  int         rst_at,
        output int         lat,
        output logic       busy0,
        output logic       done0
    );
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        lat = -1;
        busy0 = busy;
        done0 = done;
        for (int j = 0; j < 20; j++) begin
            if (done === 1'b1) begin
                lat = j;
                break;
            end
            if (j == glitch_at) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
            end
            if (j == glitch_at + 1) start = 1'b0;
            if (j == rst_at) rst = 1'b1;
            if (j == rst_at + 1) rst = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int lat; logic b0, d0;
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b, want all 0",
                     busy, done, sum, cout);
        end
        tests++;
        if ({busy1, done1, sum1, cout1} !== 4'd0) begin
            fails++;
            $display("FAIL reset_w1: busy=%b done=%b sum=%b cout=%b, want 0",
                     busy1, done1, sum1, cout1);
        end
        rst = 1'b0;
        @(negedge clk);
        run_op(8'h00, 8'h00, 1'b0, -1, -1, lat, b0, d0);
        tests++;
        if (lat != 8 || {cout, sum} !== 9'h000) begin
            fails++;
            $display("FAIL zero_add: lat=%0d sum=%h cout=%b, want lat=8 0/0",
                     lat, sum, cout);
        end
    endtask

    task automatic test_basic;
        logic [7:0] va [2];
        logic [7:0] vb [2];
        logic       vc [2];
        int lat; logic b0, d0;
        logic [8:0] exp;
        va[0] = 8'hFF; vb[0] = 8'h01; vc[0] = 1'b0;
        va[1] = 8'hA5; vb[1] = 8'h5A; vc[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp = 9'(va[i]) + 9'(vb[i]) + 9'(vc[i]);
            run_op(va[i], vb[i], vc[i], -1, -1, lat, b0, d0);
            tests++;
            if (b0 !== 1'b1 || d0 !== 1'b0) begin
                fails++;
                $display("FAIL accept_%0d: busy=%b done=%b, want 1/0", i, b0, d0);
            end
            tests++;
            if (lat != 8 || {cout, sum} !== exp) begin
                fails++;
                $display("FAIL basic_%0d: lat=%0d got=%h, want lat=8 %h",
                         i, lat, {cout, sum}, exp);
            end
            @(negedge clk);
            tests++;
            if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== exp) begin
                fails++;
                $display("FAIL pulse_%0d: done=%b busy=%b got=%h, want 0/0 %h",
                         i, done, busy, {cout, sum}, exp);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int lat; logic b0, d0;
        @(negedge clk);
        run_op(8'h12, 8'h34, 1'b0, 3, -1, lat, b0, d0);
        tests++;
        if (lat != 8 || {cout, sum} !== 9'h046) begin
            fails++;
            $display("FAIL busy_ignore: lat=%0d got=%h, want lat=8 046",
                     lat, {cout, sum});
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL no_queue: busy=%b done=%b, want 0/0", busy, done);
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic b0, d0;
        @(negedge clk);
        run_op(8'h80, 8'h80, 1'b0, -1, 4, lat, b0, d0);
        tests++;
        if (lat != -1 || {busy, done, cout, sum} !== 11'd0) begin
            fails++;
            $display("FAIL reset_mid: lat=%0d busy=%b done=%b got=%h, want none 0",
                     lat, busy, done, {cout, sum});
        end
        run_op(8'h01, 8'h01, 1'b0, -1, -1, lat, b0, d0);
        tests++;
        if (lat != 8 || {cout, sum} !== 9'h002) begin
            fails++;
            $display("FAIL after_reset: lat=%0d got=%h, want lat=8 002",
                     lat, {cout, sum});
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic b0, d0;
        @(negedge clk);
        run_op(8'h33, 8'h44, 1'b1, -1, -1, lat, b0, d0);
        tests++;
        if (lat != 8 || {cout, sum} !== 9'h078) begin
            fails++;
            $display("FAIL b2b_first: lat=%0d got=%h, want lat=8 078",
                     lat, {cout, sum});
        end
        run_op(8'h0F, 8'h01, 1'b0, -1, -1, lat, b0, d0);
        tests++;
        if (b0 !== 1'b1 || d0 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b done=%b, want 1/0", b0, d0);
        end
        tests++;
        if (lat != 8 || {cout, sum} !== 9'h010) begin
            fails++;
            $display("FAIL b2b_second: lat=%0d got=%h, want lat=8 010",
                     lat, {cout, sum});
        end
    endtask

    task automatic test_width1;
        int lat;
        logic [1:0] exp;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = 1'(i); b1 = 1'(i >> 1); cin1 = 1'(i >> 2); start1 = 1'b1;
            exp = 2'(i & 1) + 2'((i >> 1) & 1) + 2'((i >> 2) & 1);
            @(negedge clk);
            start1 = 1'b0;
            lat = -1;
            for (int j = 0; j < 6; j++) begin
                if (done1 === 1'b1) begin
                    lat = j;
                    break;
                end
                @(negedge clk);
            end
            tests++;
            if (lat != 1 || {cout1, sum1} !== exp) begin
                fails++;
                $display("FAIL w1_combo_%0d: lat=%0d got=%b, want lat=1 %b",
                         i, lat, {cout1, sum1}, exp);
            end
        end
    endtask

    task automatic test_random;
        int lat; logic b0, d0;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] exp;
        int bad;
        bad = 0;
        @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp = 9'(ra) + 9'(rb) + 9'(rc);
            run_op(ra, rb, rc, -1, -1, lat, b0, d0);
            tests++;
            if (lat != 8 || {cout, sum} !== exp) begin
                fails++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_%0d: %h+%h+%b lat=%0d got=%h, want %h",
                             i, ra, rb, rc, lat, {cout, sum}, exp);
            end
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset;
        test_basic;
        test_busy_ignore;
        test_reset_mid;
        test_back_to_back;
        test_width1;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
